// File: rtl/hm_cpl_tx.sv
// Completer for memory reads: answers each accepted MRd with a CplD built from the local
// payload RAM, or with a data-less UR completion when the request is out of range.
module hm_cpl_tx #(
    parameter int ADDR_W  = 10,
    parameter int MAX_LEN = 16
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic [7:0]        cfg_bus_number,
    input  logic [4:0]        cfg_device_number,
    input  logic [2:0]        cfg_function_number,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [15:0]       req_rid,
    input  logic [7:0]        req_tag,
    input  logic [2:0]        req_tc,
    input  logic [1:0]        req_attr,
    input  logic [ADDR_W+1:0] req_addr,
    input  logic [9:0]        req_len,
    input  logic [3:0]        req_first_be,
    input  logic [3:0]        req_last_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    input  logic [31:0]       mem_do,
    output logic [63:0]       trn_td,
    output logic [7:0]        trn_trem_n,
    output logic              trn_tsof_n,
    output logic              trn_teof_n,
    output logic              trn_tsrc_rdy_n,
    output logic              trn_tsrc_dsc_n,
    input  logic              trn_tdst_rdy_n,
    input  logic [5:0]        trn_tbuf_av,
    output logic              busy
);

    // state  | meaning
    // IDLE   | ready for a request
    // LOAD   | reading L payload DWs from RAM into the buffer
    // HDR    | waiting for completion credit, then presenting beat0
    // DATA   | presenting beats 1..N-1 until the EOF beat transfers
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_HDR  = 2'd2;
    localparam logic [1:0] S_DATA = 2'd3;

    localparam int         BUF_AW    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [9:0] MAX_LEN_W = 10'(MAX_LEN);

    logic [1:0]  state;
    logic [15:0] r_rid;
    logic [7:0]  r_tag;
    logic [2:0]  r_tc;
    logic [1:0]  r_attr;
    logic [4:0]  r_lo;
    logic [9:0]  r_len;
    logic [3:0]  r_fbe;
    logic [3:0]  r_lbe;
    logic        r_ur;
    logic [9:0]  rd_left;
    logic [9:0]  cap_idx;
    logic        rd_vld;
    logic [9:0]  beat_idx;
    logic [31:0] buffer [MAX_LEN];

    logic        req_legal;
    logic [31:0] dw0, dw1, dw2;
    logic [11:0] byte_cnt;
    logic [10:0] eff_len, tot_dw, n_beats, k2, up_idx, lo_idx;
    logic [31:0] nxt_hi, nxt_lo;
    logic        nxt_last;
    logic [7:0]  nxt_trem;
    logic        unused_bits;

    function automatic logic [1:0] low_bit(input logic [3:0] be);
        if (be[0]) return 2'd0;
        if (be[1]) return 2'd1;
        if (be[2]) return 2'd2;
        if (be[3]) return 2'd3;
        return 2'd0;
    endfunction

    function automatic logic [2:0] lead_zeros(input logic [3:0] be);
        if (be[3]) return 3'd0;
        if (be[2]) return 3'd1;
        if (be[1]) return 3'd2;
        if (be[0]) return 3'd3;
        return 3'd4;
    endfunction

    assign req_ready      = (state == S_IDLE);
    assign busy           = (state != S_IDLE);
    assign trn_tsrc_dsc_n = 1'b1;
    assign unused_bits    = ^{req_addr[1:0], trn_tbuf_av[5:3], trn_tbuf_av[1:0]};

    assign req_legal = (req_len != 10'd0) && (req_len <= MAX_LEN_W) &&
                       ((req_len == 10'd1) || (req_first_be != 4'd0));

    // A single-DW span is the same formula with first_be standing in for last_be.
    always_comb begin
        byte_cnt = 12'd4;
        if (!r_ur) begin
            if (r_len == 10'd1 && r_fbe == 4'd0)
                byte_cnt = 12'd1;
            else
                byte_cnt = {r_len, 2'b00} - 12'(low_bit(r_fbe))
                           - 12'(lead_zeros((r_len == 10'd1) ? r_fbe : r_lbe));
        end
    end

    assign dw0 = {1'b0, (r_ur ? 2'b00 : 2'b10), 5'b01010, 1'b0, r_tc, 4'b0, 2'b0, r_attr,
                  2'b0, (r_ur ? 10'd0 : r_len)};
    assign dw1 = {cfg_bus_number, cfg_device_number, cfg_function_number,
                  (r_ur ? 3'b001 : 3'b000), 1'b0, byte_cnt};
    assign dw2 = {r_rid, r_tag, 1'b0, (r_ur ? 7'd0 : {r_lo, low_bit(r_fbe)})};

    assign eff_len = r_ur ? 11'd0 : {1'b0, r_len};
    assign tot_dw  = eff_len + 11'd3;
    assign n_beats = (tot_dw + 11'd1) >> 1;
    assign k2      = {beat_idx, 1'b0};
    assign up_idx  = k2 - 11'd3;
    assign lo_idx  = k2 - 11'd2;

    // Beat k>=1 carries payload DWs 2k-3 / 2k-2; anything past the payload is zero filler.
    always_comb begin
        nxt_hi = 32'd0;
        nxt_lo = 32'd0;
        if (beat_idx == 10'd1)
            nxt_hi = dw2;
        else if (up_idx < eff_len)
            nxt_hi = buffer[up_idx[BUF_AW-1:0]];
        if (lo_idx < eff_len)
            nxt_lo = buffer[lo_idx[BUF_AW-1:0]];
        nxt_last = ({1'b0, beat_idx} == (n_beats - 11'd1));
        nxt_trem = (nxt_last && tot_dw[0]) ? 8'h0F : 8'h00;
    end

    always_ff @(posedge sys_clk) begin
        if (state == S_LOAD && rd_vld)
            buffer[cap_idx[BUF_AW-1:0]] <= mem_do;
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state          <= S_IDLE;
            trn_td         <= 64'd0;
            trn_trem_n     <= 8'h00;
            trn_tsof_n     <= 1'b1;
            trn_teof_n     <= 1'b1;
            trn_tsrc_rdy_n <= 1'b1;
            mem_re         <= 1'b0;
            mem_addr       <= '0;
            rd_vld         <= 1'b0;
            rd_left        <= 10'd0;
            cap_idx        <= 10'd0;
            beat_idx       <= 10'd0;
            r_rid          <= 16'd0;
            r_tag          <= 8'd0;
            r_tc           <= 3'd0;
            r_attr         <= 2'd0;
            r_lo           <= 5'd0;
            r_len          <= 10'd0;
            r_fbe          <= 4'd0;
            r_lbe          <= 4'd0;
            r_ur           <= 1'b0;
        end else begin
            rd_vld <= mem_re;
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_rid  <= req_rid;
                        r_tag  <= req_tag;
                        r_tc   <= req_tc;
                        r_attr <= req_attr;
                        r_lo   <= req_addr[6:2];
                        r_len  <= req_len;
                        r_fbe  <= req_first_be;
                        r_lbe  <= req_last_be;
                        r_ur   <= !req_legal;
                        if (req_legal) begin
                            state    <= S_LOAD;
                            mem_re   <= 1'b1;
                            mem_addr <= req_addr[ADDR_W+1:2];
                            rd_left  <= req_len - 10'd1;
                            cap_idx  <= 10'd0;
                        end else begin
                            state <= S_HDR;
                        end
                    end
                end
                S_LOAD: begin
                    if (mem_re) begin
                        if (rd_left == 10'd0) begin
                            mem_re <= 1'b0;
                        end else begin
                            mem_addr <= mem_addr + 1'b1;
                            rd_left  <= rd_left - 10'd1;
                        end
                    end
                    if (rd_vld) begin
                        cap_idx <= cap_idx + 10'd1;
                        if (cap_idx == r_len - 10'd1)
                            state <= S_HDR;
                    end
                end
                S_HDR: begin
                    if (trn_tsrc_rdy_n) begin
                        if (trn_tbuf_av[2]) begin
                            trn_td         <= {dw0, dw1};
                            trn_trem_n     <= 8'h00;
                            trn_tsof_n     <= 1'b0;
                            trn_teof_n     <= 1'b1;
                            trn_tsrc_rdy_n <= 1'b0;
                            beat_idx       <= 10'd1;
                        end
                    end else if (!trn_tdst_rdy_n) begin
                        trn_td     <= {nxt_hi, nxt_lo};
                        trn_trem_n <= nxt_trem;
                        trn_tsof_n <= 1'b1;
                        trn_teof_n <= !nxt_last;
                        beat_idx   <= beat_idx + 10'd1;
                        state      <= S_DATA;
                    end
                end
                default: begin
                    if (!trn_tdst_rdy_n) begin
                        if (!trn_teof_n) begin
                            trn_td         <= 64'd0;
                            trn_trem_n     <= 8'h00;
                            trn_teof_n     <= 1'b1;
                            trn_tsrc_rdy_n <= 1'b1;
                            state          <= S_IDLE;
                        end else begin
                            trn_td     <= {nxt_hi, nxt_lo};
                            trn_trem_n <= nxt_trem;
                            trn_teof_n <= !nxt_last;
                            beat_idx   <= beat_idx + 10'd1;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hm_cpl_tx.sv
// Directed bench for hm_cpl_tx: a synchronous RAM model feeds the DUT and a negedge monitor
// records every transferred beat for comparison against hand-computed completions.
module tb_hm_cpl_tx;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic [7:0]  cfg_bus_number = 8'hFF;
    logic [4:0]  cfg_device_number = 5'h1F;
    logic [2:0]  cfg_function_number = 3'h7;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [15:0] req_rid = 16'd0;
    logic [7:0]  req_tag = 8'd0;
    logic [2:0]  req_tc = 3'd0;
    logic [1:0]  req_attr = 2'd0;
    logic [11:0] req_addr = 12'd0;
    logic [9:0]  req_len = 10'd1;
    logic [3:0]  req_first_be = 4'd0;
    logic [3:0]  req_last_be = 4'd0;
    logic [9:0]  mem_addr;
    logic        mem_re;
    logic [31:0] mem_do = 32'd0;
    logic [63:0] trn_td;
    logic [7:0]  trn_trem_n;
    logic        trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n, trn_tsrc_dsc_n;
    logic        trn_tdst_rdy_n = 1'b0;
    logic [5:0]  trn_tbuf_av = 6'h3F;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int sof_cyc = 0;
    int re_cnt = 0;
    int eof_cnt = 0;
    int src_low = 0;
    bit sof_seen = 0;

    logic [63:0] q_td[$];
    logic [7:0]  q_trem[$];
    logic        q_sof[$];
    logic        q_eof[$];
    logic [31:0] ram [1024];

    hm_cpl_tx #(.ADDR_W(10), .MAX_LEN(16)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .cfg_bus_number(cfg_bus_number), .cfg_device_number(cfg_device_number),
        .cfg_function_number(cfg_function_number),
        .req_valid(req_valid), .req_ready(req_ready), .req_rid(req_rid), .req_tag(req_tag),
        .req_tc(req_tc), .req_attr(req_attr), .req_addr(req_addr), .req_len(req_len),
        .req_first_be(req_first_be), .req_last_be(req_last_be),
        .mem_addr(mem_addr), .mem_re(mem_re), .mem_do(mem_do),
        .trn_td(trn_td), .trn_trem_n(trn_trem_n), .trn_tsof_n(trn_tsof_n),
        .trn_teof_n(trn_teof_n), .trn_tsrc_rdy_n(trn_tsrc_rdy_n),
        .trn_tsrc_dsc_n(trn_tsrc_dsc_n), .trn_tdst_rdy_n(trn_tdst_rdy_n),
        .trn_tbuf_av(trn_tbuf_av), .busy(busy)
    );

    always #5 sys_clk = ~sys_clk;

    initial for (int i = 0; i < 1024; i++) ram[i] = 32'hD000_0000 | 32'(i);

    always @(posedge sys_clk) begin
        cyc <= cyc + 1;
        if (mem_re) mem_do <= ram[mem_addr];
    end

    // A beat presented with both ready lines low at the negedge transfers on the next posedge.
    always @(negedge sys_clk) begin
        if (mem_re) re_cnt++;
        if (!trn_tsrc_rdy_n && !trn_tsof_n && !sof_seen) begin
            sof_seen = 1;
            sof_cyc  = cyc;
        end
        if (!trn_tsrc_rdy_n && !trn_tdst_rdy_n) begin
            q_td.push_back(trn_td);
            q_trem.push_back(trn_trem_n);
            q_sof.push_back(trn_tsof_n);
            q_eof.push_back(trn_teof_n);
            if (!trn_teof_n) eof_cnt++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic clear_mon();
        q_td.delete();
        q_trem.delete();
        q_sof.delete();
        q_eof.delete();
        re_cnt   = 0;
        eof_cnt  = 0;
        sof_seen = 0;
    endtask

    task automatic check_reset_vals(input string pfx);
        chk({pfx, "_td"}, trn_td, 64'd0);
        chk({pfx, "_trem"}, 64'(trn_trem_n), 64'h00);
        chk({pfx, "_sof"}, 64'(trn_tsof_n), 64'd1);
        chk({pfx, "_eof"}, 64'(trn_teof_n), 64'd1);
        chk({pfx, "_src_rdy"}, 64'(trn_tsrc_rdy_n), 64'd1);
        chk({pfx, "_dsc"}, 64'(trn_tsrc_dsc_n), 64'd1);
        chk({pfx, "_mem_re"}, 64'(mem_re), 64'd0);
        chk({pfx, "_mem_addr"}, 64'(mem_addr), 64'd0);
        chk({pfx, "_busy"}, 64'(busy), 64'd0);
        chk({pfx, "_req_ready"}, 64'(req_ready), 64'd1);
    endtask

    task automatic send(input logic [15:0] rid, input logic [7:0] tag, input logic [11:0] addr,
                        input logic [9:0] len, input logic [3:0] fbe, input logic [3:0] lbe);
        clear_mon();
        req_rid = rid; req_tag = tag; req_addr = addr; req_len = len;
        req_first_be = fbe; req_last_be = lbe; req_valid = 1'b1;
        for (int n = 0; n < 50 && !req_ready; n++) tick();
        chk("req_ready_before_accept", 64'(req_ready), 64'd1);
        tick();
        acc_cyc   = cyc;
        req_valid = 1'b0;
    endtask

    task automatic wait_tlp();
        for (int n = 0; n < 300 && eof_cnt == 0; n++) tick();
        chk("tlp_completed", 64'(eof_cnt > 0), 64'd1);
        tick();
    endtask

    initial begin
        tick(); tick();
        sys_rst = 1'b0;
        tick();
        check_reset_vals("reset");

        // 1) single DW, full enables
        send(16'hABCD, 8'h5A, 12'h004, 10'd1, 4'hF, 4'h0);
        wait_tlp();
        chk("t1_beats", 64'(q_td.size()), 64'd2);
        chk("t1_beat0", q_td[0], 64'h4A000001_FFFF0004);
        chk("t1_beat1", q_td[1], 64'hABCD5A04_D0000001);
        chk("t1_sof0", 64'(q_sof[0]), 64'd0);
        chk("t1_eof0", 64'(q_eof[0]), 64'd1);
        chk("t1_eof1", 64'(q_eof[1]), 64'd0);
        chk("t1_trem1", 64'(q_trem[1]), 64'h00);
        chk("t1_latency", 64'(sof_cyc - acc_cyc), 64'd3);
        chk("t1_mem_re", 64'(re_cnt), 64'd1);

        // 2) two DWs -> odd DW count, half last beat
        send(16'hABCD, 8'h01, 12'h010, 10'd2, 4'hF, 4'hF);
        wait_tlp();
        chk("t2_beats", 64'(q_td.size()), 64'd3);
        chk("t2_beat0", q_td[0], 64'h4A000002_FFFF0008);
        chk("t2_beat1", q_td[1], 64'hABCD0110_D0000004);
        chk("t2_beat2_hi", 64'(q_td[2][63:32]), 64'hD0000005);
        chk("t2_trem2", 64'(q_trem[2]), 64'h0F);
        chk("t2_eof2", 64'(q_eof[2]), 64'd0);

        // 3) single DW with partial first_be
        send(16'hABCD, 8'h02, 12'h008, 10'd1, 4'b0110, 4'h0);
        wait_tlp();
        chk("t3_beat0", q_td[0], 64'h4A000001_FFFF0002);
        chk("t3_beat1", q_td[1], 64'hABCD0209_D0000002);

        // 4) back-pressure while beat1 is presented
        send(16'h1234, 8'h07, 12'h100, 10'd3, 4'hF, 4'hF);
        for (int n = 0; n < 50 && !(!trn_tsof_n && !trn_tsrc_rdy_n); n++) tick();
        chk("t4_sof_seen", 64'(!trn_tsof_n && !trn_tsrc_rdy_n), 64'd1);
        tick();
        trn_tdst_rdy_n = 1'b1;
        for (int n = 0; n < 5; n++) begin
            chk("t4_hold_td", trn_td, 64'h12340700_D0000040);
            chk("t4_hold_eof", 64'(trn_teof_n), 64'd1);
            chk("t4_hold_trem", 64'(trn_trem_n), 64'h00);
            tick();
        end
        trn_tdst_rdy_n = 1'b0;
        wait_tlp();
        chk("t4_beats", 64'(q_td.size()), 64'd3);
        chk("t4_beat1", q_td[1], 64'h12340700_D0000040);
        chk("t4_beat2", q_td[2], 64'hD0000041_D0000042);
        chk("t4_trem2", 64'(q_trem[2]), 64'h00);
        chk("t4_eof2", 64'(q_eof[2]), 64'd0);

        // 5) length above MAX_LEN -> UR
        send(16'hABCD, 8'h5B, 12'h004, 10'h020, 4'hF, 4'hF);
        wait_tlp();
        chk("t5_beats", 64'(q_td.size()), 64'd2);
        chk("t5_beat0", q_td[0], 64'h0A000000_FFFF2004);
        chk("t5_beat1_hi", 64'(q_td[1][63:32]), 64'hABCD5B00);
        chk("t5_trem1", 64'(q_trem[1]), 64'h0F);
        chk("t5_no_mem_re", 64'(re_cnt), 64'd0);

        // multi-DW with first_be==0 is also UR
        send(16'hABCD, 8'h09, 12'h004, 10'd2, 4'h0, 4'hF);
        wait_tlp();
        chk("ur_fbe0_beat0", q_td[0], 64'h0A000000_FFFF2004);

        // RAM address wraps past the top DW; last_be trims the byte count
        send(16'hABCD, 8'h08, 12'hFFC, 10'd2, 4'hF, 4'h1);
        wait_tlp();
        chk("wrap_beat0", q_td[0], 64'h4A000002_FFFF0005);
        chk("wrap_beat1", q_td[1], 64'hABCD087C_D00003FF);
        chk("wrap_beat2_hi", 64'(q_td[2][63:32]), 64'hD0000000);

        // largest legal length
        send(16'h0000, 8'h10, 12'h000, 10'd16, 4'hF, 4'hF);
        wait_tlp();
        chk("max_beats", 64'(q_td.size()), 64'd10);
        chk("max_beat0", q_td[0], 64'h4A000010_FFFF0040);
        chk("max_last_hi", 64'(q_td[9][63:32]), 64'hD000000F);
        chk("max_last_trem", 64'(q_trem[9]), 64'h0F);
        chk("max_last_eof", 64'(q_eof[9]), 64'd0);
        chk("max_mem_re", 64'(re_cnt), 64'd16);
        chk("max_latency", 64'(sof_cyc - acc_cyc), 64'd18);

        // 6) no completion credit, then reset in the middle of DATA
        trn_tbuf_av = 6'b111011;
        send(16'h4321, 8'h33, 12'h040, 10'd4, 4'hF, 4'hF);
        src_low = 0;
        for (int n = 0; n < 10; n++) begin
            tick();
            if (!trn_tsrc_rdy_n) src_low++;
        end
        chk("t6_no_sof_without_credit", 64'(src_low), 64'd0);
        chk("t6_busy_waiting", 64'(busy), 64'd1);
        trn_tbuf_av = 6'h3F;
        for (int n = 0; n < 50 && q_td.size() < 2; n++) tick();
        chk("t6_reached_data", 64'(q_td.size() >= 2), 64'd1);
        sys_rst = 1'b1;
        #1;
        check_reset_vals("t6_in_reset");
        tick();
        sys_rst = 1'b0;
        tick();
        check_reset_vals("t6_after_reset");
        send(16'h0F0F, 8'h44, 12'h00C, 10'd2, 4'hC, 4'h3);
        wait_tlp();
        chk("t6_beats", 64'(q_td.size()), 64'd3);
        chk("t6_beat0", q_td[0], 64'h4A000002_FFFF0004);
        chk("t6_beat1", q_td[1], 64'h0F0F440E_D0000003);
        chk("t6_beat2_hi", 64'(q_td[2][63:32]), 64'hD0000004);
        chk("t6_trem2", 64'(q_trem[2]), 64'h0F);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
